// File: rtl/fc_buf_pkg.sv
// Shared definitions for the FC-layer ifmap ping-pong buffer.
//   FC_DATA_W / FC_DEPTH / FC_LANES : default word width, bank depth, read lanes
//   ifmap_t                         : one signed ifmap word at the default width
package fc_buf_pkg;
   localparam int FC_DATA_W = 8;
   localparam int FC_DEPTH  = 128;
   localparam int FC_LANES  = 4;

   typedef logic signed [FC_DATA_W-1:0] ifmap_t;
endpackage

// File: rtl/fc_buf_bank.sv
// One ifmap bank: DEPTH x DATA_W storage, single write port, LANES-wide
// registered read of consecutive words with the address wrapping in the bank.
//   clk, rst        : clock, async active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i    : read strobe and base address
//   rdata_o         : registered read data, lane k at [k*DATA_W +: DATA_W]
module fc_buf_bank
   import fc_buf_pkg::*;
#(
   parameter int DATA_W = FC_DATA_W,
   parameter int DEPTH  = FC_DEPTH,
   parameter int LANES  = FC_LANES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic                       re_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [LANES*DATA_W-1:0]    rdata_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0]       mem [DEPTH];
   logic [LANES*DATA_W-1:0] rdata_d, rdata_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // DEPTH is a power of two, so AW-bit addition gives the modulo wrap.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         for (int k = 0; k < LANES; k++) begin
            rdata_d[k*DATA_W +: DATA_W] = mem[raddr_i + AW'(k)];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/fc_ifmap_pp_buf.sv
// Ping-pong ifmap buffer between the pooling/flatten stage and the FC MAC
// array. The loader fills one bank while the FC engine reads LANES words per
// cycle from the other; ownership changes on wr_done_i / rd_done_i pulses.
//   wren_i/wrptr_i/ifmap_i, wr_done_i, wr_ready_o : loader side
//   rden_i/rdptr_i, rd_done_i, rd_ready_o         : FC engine side
//   ifmap_o/ifmap_vld_o : read data (1-cycle latency), held when not valid
//   err_o               : sticky protocol error, cleared by rst only
module fc_ifmap_pp_buf
   import fc_buf_pkg::*;
#(
   parameter int DATA_W = FC_DATA_W,
   parameter int DEPTH  = FC_DEPTH,
   parameter int LANES  = FC_LANES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wren_i,
   input  logic [$clog2(DEPTH)-1:0]   wrptr_i,
   input  logic [DATA_W-1:0]          ifmap_i,
   input  logic                       wr_done_i,
   output logic                       wr_ready_o,
   input  logic                       rden_i,
   input  logic [$clog2(DEPTH)-1:0]   rdptr_i,
   input  logic                       rd_done_i,
   output logic                       rd_ready_o,
   output logic [LANES*DATA_W-1:0]    ifmap_o,
   output logic                       ifmap_vld_o,
   output logic                       err_o
);
   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       err_q, err_d;
   logic       vld_q, vld_d;
   logic       rd_sel_q, rd_sel_d;

   logic       wr_ok, rd_ok;
   logic [1:0] we, re;
   logic [LANES*DATA_W-1:0] bank_rdata [2];

   assign wr_ready_o = !full_q[wr_bank_q];
   assign rd_ready_o = full_q[rd_bank_q];

   assign wr_ok = wren_i && wr_ready_o;
   assign rd_ok = rden_i && rd_ready_o;

   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      err_d     = err_q;
      vld_d     = rd_ok;
      // rd_sel remembers which bank feeds ifmap_o so the output holds
      // even after the reader has released that bank.
      rd_sel_d  = rd_ok ? rd_bank_q : rd_sel_q;
      we        = '0;
      re        = '0;

      we[wr_bank_q] = wr_ok;
      re[rd_bank_q] = rd_ok;

      if (wren_i    && !wr_ready_o) err_d = 1'b1;
      if (rden_i    && !rd_ready_o) err_d = 1'b1;
      if (wr_done_i && !wr_ready_o) err_d = 1'b1;
      if (rd_done_i && !rd_ready_o) err_d = 1'b1;

      // Both handovers may fire together: one needs full=0, the other
      // full=1, so they never touch the same bank.
      if (wr_done_i && wr_ready_o) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = !wr_bank_q;
      end
      if (rd_done_i && rd_ready_o) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= 2'b00;
         err_q     <= 1'b0;
         vld_q     <= 1'b0;
         rd_sel_q  <= 1'b0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         err_q     <= err_d;
         vld_q     <= vld_d;
         rd_sel_q  <= rd_sel_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fc_buf_bank #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .LANES  (LANES)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (we[b]),
         .waddr_i (wrptr_i),
         .wdata_i (ifmap_i),
         .re_i    (re[b]),
         .raddr_i (rdptr_i),
         .rdata_o (bank_rdata[b])
      );
   end

   assign ifmap_o     = bank_rdata[rd_sel_q];
   assign ifmap_vld_o = vld_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_fc_ifmap_pp_buf.sv
module tb_fc_ifmap_pp_buf;
   logic        clk = 1'b0;
   logic        rst;
   logic        wren, wr_done, rden, rd_done;
   logic [6:0]  wrptr, rdptr;
   logic [7:0]  ifmap_in;
   logic        wr_ready_o, rd_ready_o, ifmap_vld_o, err_o;
   logic [31:0] ifmap_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: two word arrays plus ownership/full bookkeeping.
   logic [7:0]  m_mem [2][128];
   int          m_wrb, m_rdb;
   bit          m_full [2];
   bit          m_err, m_vld;
   logic [31:0] m_ifmap;

   always #5 clk = ~clk;

   fc_ifmap_pp_buf dut (
      .clk         (clk),
      .rst         (rst),
      .wren_i      (wren),
      .wrptr_i     (wrptr),
      .ifmap_i     (ifmap_in),
      .wr_done_i   (wr_done),
      .wr_ready_o  (wr_ready_o),
      .rden_i      (rden),
      .rdptr_i     (rdptr),
      .rd_done_i   (rd_done),
      .rd_ready_o  (rd_ready_o),
      .ifmap_o     (ifmap_o),
      .ifmap_vld_o (ifmap_vld_o),
      .err_o       (err_o)
   );

   task automatic idle();
      wren = 0; wr_done = 0; rden = 0; rd_done = 0;
   endtask

   task automatic model_reset();
      m_wrb = 0; m_rdb = 0; m_full[0] = 0; m_full[1] = 0;
      m_err = 0; m_vld = 0; m_ifmap = '0;
   endtask

   task automatic model_step();
      bit wr_rdy, rd_rdy;
      if (rst) begin
         model_reset();
         return;
      end
      wr_rdy = !m_full[m_wrb];
      rd_rdy = m_full[m_rdb];
      m_vld = 0;
      if (rden) begin
         if (rd_rdy) begin
            for (int k = 0; k < 4; k++) m_ifmap[k*8 +: 8] = m_mem[m_rdb][(int'(rdptr) + k) % 128];
            m_vld = 1;
         end else m_err = 1;
      end
      if (wren) begin
         if (wr_rdy) m_mem[m_wrb][wrptr] = ifmap_in;
         else m_err = 1;
      end
      if (wr_done) begin
         if (wr_rdy) begin m_full[m_wrb] = 1; m_wrb ^= 1; end
         else m_err = 1;
      end
      if (rd_done) begin
         if (rd_rdy) begin m_full[m_rdb] = 0; m_rdb ^= 1; end
         else m_err = 1;
      end
   endtask

   // Advance one clock; inputs stay stable across the edge, outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1; idle(); wrptr = 0; rdptr = 0; ifmap_in = 0;
      tick(); tick();
      rst = 0;
      tick();
      n_checks += 5;
      if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready_o); end
      if (rd_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_o); end
      if (ifmap_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", ifmap_vld_o); end
      if (ifmap_o !== 32'h0) begin n_fail++; $display("FAIL reset_ifmap got %h exp 0", ifmap_o); end
   endtask

   task automatic test_fill_read();
      for (int i = 0; i < 128; i++) begin
         wren = 1; wrptr = 7'(i); ifmap_in = 8'(i);
         tick();
      end
      wren = 0; wr_done = 1;
      tick();
      wr_done = 0;
      n_checks += 2;
      if (rd_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_rd_ready got %b exp 1", rd_ready_o); end
      if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_wr_ready got %b exp 1", wr_ready_o); end
      rden = 1; rdptr = 8;
      tick();
      rden = 0;
      n_checks += 2;
      if (ifmap_vld_o !== 1'b1) begin n_fail++; $display("FAIL read8_vld got %b exp 1", ifmap_vld_o); end
      if (ifmap_o !== 32'h0B0A0908) begin n_fail++; $display("FAIL read8_data got %h exp 0b0a0908", ifmap_o); end
      tick();
      n_checks += 2;
      if (ifmap_vld_o !== 1'b0) begin n_fail++; $display("FAIL read8_vld_drop got %b exp 0", ifmap_vld_o); end
      if (ifmap_o !== 32'h0B0A0908) begin n_fail++; $display("FAIL read8_hold got %h exp 0b0a0908", ifmap_o); end
   endtask

   task automatic test_wrap();
      rden = 1; rdptr = 126;
      tick();
      rden = 0;
      n_checks += 2;
      if (ifmap_vld_o !== 1'b1) begin n_fail++; $display("FAIL wrap_vld got %b exp 1", ifmap_vld_o); end
      if (ifmap_o !== 32'h01007F7E) begin n_fail++; $display("FAIL wrap_data got %h exp 01007f7e", ifmap_o); end
   endtask

   task automatic test_pingpong();
      logic [31:0] exp;
      int rp;
      for (int i = 0; i < 128; i++) begin
         wren = 1; wrptr = 7'(i); ifmap_in = 8'(i + 8'h40);
         rp = int'($urandom_range(0, 127));
         rden = 1; rdptr = 7'(rp);
         tick();
         for (int k = 0; k < 4; k++) exp[k*8 +: 8] = 8'((rp + k) % 128);
         n_checks += 2;
         if (ifmap_vld_o !== 1'b1) begin n_fail++; $display("FAIL pp_vld i=%0d got %b exp 1", i, ifmap_vld_o); end
         if (ifmap_o !== exp) begin n_fail++; $display("FAIL pp_data i=%0d ptr=%0d got %h exp %h", i, rp, ifmap_o, exp); end
      end
      wren = 0; rden = 0; wr_done = 1; rd_done = 1;
      tick();
      wr_done = 0; rd_done = 0;
      n_checks += 2;
      if (rd_ready_o !== 1'b1) begin n_fail++; $display("FAIL pp_swap_rd_ready got %b exp 1", rd_ready_o); end
      if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL pp_swap_wr_ready got %b exp 1", wr_ready_o); end
      rden = 1; rdptr = 0;
      tick();
      rden = 0;
      n_checks += 2;
      if (ifmap_o !== 32'h43424140) begin n_fail++; $display("FAIL pp_bank1_data got %h exp 43424140", ifmap_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL pp_err got %b exp 0", err_o); end
   endtask

   task automatic test_both_full();
      logic [7:0] v5, d;
      v5 = 8'h00;
      for (int i = 0; i < 128; i++) begin
         d = 8'($urandom);
         if (i == 5) begin
            if (d == 8'h7F) d = 8'h7E;
            v5 = d;
         end
         wren = 1; wrptr = 7'(i); ifmap_in = d;
         tick();
      end
      wren = 0; wr_done = 1;
      tick();
      wr_done = 0;
      n_checks += 2;
      if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready got %b exp 0", wr_ready_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL full_err_pre got %b exp 0", err_o); end
      wren = 1; wrptr = 5; ifmap_in = 8'h7F;
      tick();
      wren = 0;
      n_checks += 1;
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b exp 1", err_o); end
      rd_done = 1;
      tick();
      rd_done = 0;
      rden = 1; rdptr = 5;
      tick();
      rden = 0;
      n_checks += 2;
      if (ifmap_o[7:0] !== v5) begin n_fail++; $display("FAIL drop_old_value got %h exp %h", ifmap_o[7:0], v5); end
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err_o); end
   endtask

   task automatic test_random();
      rst = 1; idle();
      tick();
      rst = 0;
      for (int c = 0; c < 400; c++) begin
         wren     = ($urandom_range(0, 1) == 1);
         wrptr    = 7'($urandom);
         ifmap_in = 8'($urandom);
         rden     = ($urandom_range(0, 1) == 1);
         rdptr    = 7'($urandom);
         wr_done  = ($urandom_range(0, 15) == 0);
         rd_done  = ($urandom_range(0, 15) == 0);
         tick();
         n_checks += 5;
         if (wr_ready_o !== !m_full[m_wrb]) begin n_fail++; $display("FAIL rnd_wr_ready c=%0d got %b exp %b", c, wr_ready_o, !m_full[m_wrb]); end
         if (rd_ready_o !== m_full[m_rdb]) begin n_fail++; $display("FAIL rnd_rd_ready c=%0d got %b exp %b", c, rd_ready_o, m_full[m_rdb]); end
         if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got %b exp %b", c, err_o, m_err); end
         if (ifmap_vld_o !== m_vld) begin n_fail++; $display("FAIL rnd_vld c=%0d got %b exp %b", c, ifmap_vld_o, m_vld); end
         if (ifmap_o !== m_ifmap) begin n_fail++; $display("FAIL rnd_ifmap c=%0d got %h exp %h", c, ifmap_o, m_ifmap); end
      end
      idle();
   endtask

   task automatic test_reset_midread();
      rst = 1;
      tick();
      rst = 0;
      rd_done = 1;
      tick();
      rd_done = 0;
      n_checks += 1;
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL rd_done_unready_err got %b exp 1", err_o); end
      for (int i = 0; i < 4; i++) begin
         wren = 1; wrptr = 7'(i); ifmap_in = 8'(8'hA0 + i);
         tick();
      end
      wren = 0; wr_done = 1;
      tick();
      wr_done = 0;
      rden = 1; rdptr = 0;
      tick();
      rden = 0;
      n_checks += 2;
      if (ifmap_vld_o !== 1'b1) begin n_fail++; $display("FAIL mid_vld_pre got %b exp 1", ifmap_vld_o); end
      if (ifmap_o !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL mid_data_pre got %h exp a3a2a1a0", ifmap_o); end
      #2 rst = 1;
      #1;
      n_checks += 4;
      if (ifmap_vld_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got %b exp 0", ifmap_vld_o); end
      if (rd_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd_ready got %b exp 0", rd_ready_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b exp 0", err_o); end
      if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_wr_ready got %b exp 1", wr_ready_o); end
      tick();
      rst = 0;
      tick();
      n_checks += 2;
      if (ifmap_vld_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_vld got %b exp 0", ifmap_vld_o); end
      if (ifmap_o !== 32'h0) begin n_fail++; $display("FAIL post_rst_ifmap got %h exp 0", ifmap_o); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill_read();
      test_wrap();
      test_pingpong();
      test_both_full();
      test_random();
      test_reset_midread();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
